scan_seq_2b: RTL

SCAN_SEQ_2B -- requirements
Module: scan_seq_2b

---
 rtl/scan_seq_2b_if.sv | 26 ++
 rtl/scan_seq_2b.sv | 133 +++++++++++++
 2 files changed

// File: rtl/scan_seq_2b_if.sv
// Control/status bundle for the 2-bit decoder scan sequencer.
interface scan_seq_2b_if #(
    parameter int DW_W = 8,
    parameter int BL_W = 4
);
    logic            start;
    logic            stop;
    logic            mode;
    logic [3:0]      mask;
    logic [DW_W-1:0] dwell;
    logic [BL_W-1:0] blank;
    logic            en;
    logic [1:0]      Din;
    logic            busy;
    logic            done;

    modport master (
        output start, stop, mode, mask, dwell, blank,
        input  en, Din, busy, done
    );

    modport slave (
        input  start, stop, mode, mask, dwell, blank,
        output en, Din, busy, done
    );
endinterface

// File: rtl/scan_seq_2b.sv
// Scans enabled channels of a 2-to-4 decoder with blanking and dwell timing;
// every output is a flop loaded from the next-state values.
module scan_seq_2b #(
    parameter int DW_W = 8,
    parameter int BL_W = 4
) (
    input logic          clk,
    input logic          rst,
    scan_seq_2b_if.slave bus
);
    localparam int CW = (DW_W > BL_W) ? DW_W : BL_W;

    typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;

    state_t          state, state_n;
    logic [1:0]      ch, ch_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            latch, done_n;
    logic            mode_q, stop_q;
    logic [3:0]      mask_q;
    logic [DW_W-1:0] dwell_q;
    logic [BL_W-1:0] blank_q;
    logic            en_q, busy_q, done_q;
    logic [1:0]      din_q;

    function automatic logic [1:0] first_ch(input logic [3:0] m);
        first_ch = 2'd0;
        for (int unsigned i = 4; i > 0; i--)
            if (m[i-1]) first_ch = 2'(i - 1);
    endfunction

    function automatic logic [1:0] last_ch(input logic [3:0] m);
        last_ch = 2'd0;
        for (int unsigned i = 0; i < 4; i++)
            if (m[i]) last_ch = 2'(i);
    endfunction

    // Smallest forward offset wins; falls back to c when it is the only channel.
    function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] c);
        logic [1:0] cand;
        next_ch = c;
        for (int unsigned i = 3; i >= 1; i--) begin
            cand = c + 2'(i);
            if (m[cand]) next_ch = cand;
        end
    endfunction

    always_comb begin
        state_n = state;
        ch_n    = ch;
        cnt_n   = cnt;
        latch   = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && bus.mask != '0) begin
                    latch = 1'b1;
                    ch_n  = first_ch(bus.mask);
                    if (bus.blank != '0) begin
                        state_n = BLANK;
                        cnt_n   = CW'(bus.blank) - CW'(1);
                    end else begin
                        state_n = DWELL;
                        cnt_n   = CW'(bus.dwell);
                    end
                end
            end
            BLANK: begin
                if (cnt == '0) begin
                    state_n = DWELL;
                    cnt_n   = CW'(dwell_q);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            DWELL: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (stop_q || bus.stop || (mode_q && ch == last_ch(mask_q))) begin
                    state_n = IDLE;
                    ch_n    = 2'd0;
                    done_n  = 1'b1;
                end else begin
                    ch_n = next_ch(mask_q, ch);
                    if (blank_q != '0) begin
                        state_n = BLANK;
                        cnt_n   = CW'(blank_q) - CW'(1);
                    end else begin
                        cnt_n = CW'(dwell_q);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ch      <= 2'd0;
            cnt     <= '0;
            mode_q  <= 1'b0;
            mask_q  <= '0;
            dwell_q <= '0;
            blank_q <= '0;
            stop_q  <= 1'b0;
            en_q    <= 1'b1;
            din_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state <= state_n;
            ch    <= ch_n;
            cnt   <= cnt_n;
            if (latch) begin
                mode_q  <= bus.mode;
                mask_q  <= bus.mask;
                dwell_q <= bus.dwell;
                blank_q <= bus.blank;
            end
            stop_q <= (state_n == IDLE) ? 1'b0 : (stop_q || (state != IDLE && bus.stop));
            en_q   <= (state_n != DWELL);
            din_q  <= (state_n == IDLE) ? 2'd0 : ch_n;
            busy_q <= (state_n != IDLE);
            done_q <= done_n;
        end
    end

    assign bus.en   = en_q;
    assign bus.Din  = din_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
